// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM memory-stage controller.
// Includes the byte-enable legality check used when ALIGN_CHECK_EN is defined.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_DATA_WIDTH = 32;
    localparam int unsigned SRAM_ADDR_WIDTH = 8;
    localparam int unsigned NUM_LANES       = SRAM_DATA_WIDTH / 8;
    localparam logic [NUM_LANES-1:0] BE_FULL = '1;

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdWait,
        StRmwRd,
        StRmwWait,
        StWrCmd,
        StResp
    } ctrl_state_e;

    // Legal only for a naturally aligned byte, half-word or word at the given offset.
    function automatic logic be_is_legal(input logic [NUM_LANES-1:0] be, input logic [1:0] off);
        logic legal;
        legal = 1'b0;
        case (be)
            4'b0001: legal = (off == 2'd0);
            4'b0010: legal = (off == 2'd1);
            4'b0100: legal = (off == 2'd2);
            4'b1000: legal = (off == 2'd3);
            4'b0011: legal = (off == 2'd0);
            4'b1100: legal = (off == 2'd2);
            4'b1111: legal = (off == 2'd0);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Request/response bus between the load/store unit (master) and the SRAM controller (slave).
interface sram_mem_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH
);

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_byte_merge.sv
// Lane-wise merge of store data over the word read back from SRAM (read-modify-write).
module sram_byte_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic [DATA_WIDTH-1:0]   merged
);

    for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_lane
        assign merged[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : rdata[i*8 +: 8];
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller driving a single-port SRAM; partial stores become read-modify-write.
// Define ALIGN_CHECK_EN to reject stores with misaligned or non-contiguous byte enables.
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_ctrl_if.slave        bus,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

    ctrl_state_e state_q, state_d;

    logic [LANES-1:0]      be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  csb_q, web_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  accept;
    logic                  reject;
    logic [DATA_WIDTH-1:0] merged;

    assign accept = bus.req_valid && (state_q == StIdle);

`ifdef ALIGN_CHECK_EN
    assign reject = bus.req_we && !be_is_legal(bus.req_be, bus.req_addr[1:0]);
`else
    assign reject = 1'b0;
`endif

    sram_byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (sram_dout),
        .merged(merged)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (reject) begin
                        state_d = StResp;
                    end else if (!bus.req_we) begin
                        state_d = StRdCmd;
                    end else if (bus.req_be == BE_FULL) begin
                        state_d = StWrCmd;
                    end else if (bus.req_be == '0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRdCmd:   state_d = StRdWait;
            StRdWait:  state_d = StResp;
            StRmwRd:   state_d = StRmwWait;
            StRmwWait: state_d = StWrCmd;
            StWrCmd:   state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // SRAM pins are registered off the next state so each command lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            csb_q <= !(state_d inside {StRdCmd, StRmwRd, StWrCmd});
            web_q <= (state_d != StWrCmd);
            if (accept) begin
                addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
                din_q   <= bus.req_wdata;
                be_q    <= bus.req_be;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= reject;
            end
            if (state_q == StRdWait) begin
                rdata_q <= sram_dout;
            end
            if (state_q == StRmwWait) begin
                din_q <= merged;
            end
        end
    end

    assign sram_csb      = csb_q;
    assign sram_web      = web_q;
    assign sram_addr     = addr_q;
    assign sram_din      = din_q;
    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl with a behavioural single-port SRAM model.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_csb, sram_web;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = '0;

    logic [31:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic prev_csb = 1'b1;
    int   rise_cyc = 0;

    sram_mem_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    sram_mem_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sram_csb (sram_csb),
        .sram_web (sram_web),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: command sampled on posedge, read data available before the next posedge.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (!sram_csb) begin
            if (!sram_web) begin
                mem[sram_addr] <= sram_din;
                wr_cnt <= wr_cnt + 1;
            end else begin
                sram_dout <= mem[sram_addr];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (bus.rsp_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rsp_valid;
        if (!sram_csb) check("csb back-to-back", {31'd0, prev_csb}, 32'd1);
        prev_csb = sram_csb;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected response", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
                check("latency", 32'(rise_cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [9:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_be = be; bus.req_wdata = wdata;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("req_ready timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{exp_rdata, exp_err, exp_lat, cyc + 1});
        @(posedge clk);
        #1;
        // Scramble the request to prove fields were captured at acceptance.
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = ~addr;
        bus.req_be = ~be; bus.req_wdata = ~wdata;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            check("response timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input string name, input logic we, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_rd, input int exp_wr);
        int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        issue(we, addr, be, wdata, exp_rdata, exp_err, exp_lat, 1'b1);
        wait_drain();
        check({name, " reads"}, 32'(rd_cnt - r0), 32'(exp_rd));
        check({name, " writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_be = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset csb", {31'd0, sram_csb}, 32'd1);
        check("reset web", {31'd0, sram_web}, 32'd1);
        check("reset addr", {24'd0, sram_addr}, 32'd0);
        check("reset din", sram_din, 32'd0);
        check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);

        preload(8'h05, 32'hDEADBEEF);
        run_op("load 0x14", 1'b0, 10'h014, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);

        run_op("full store", 1'b1, 10'h020, 4'b1111, 32'h12345678, 32'h0, 1'b0, 2, 0, 1);
        run_op("load 0x20", 1'b0, 10'h020, 4'b1111, 32'h0, 32'h12345678, 1'b0, 3, 1, 0);

        preload(8'h08, 32'hAABBCCDD);
        run_op("partial store", 1'b1, 10'h022, 4'b0100, 32'h00EE0000, 32'h0, 1'b0, 4, 1, 1);
        run_op("load merged", 1'b0, 10'h020, 4'b0000, 32'h0, 32'hAAEECCDD, 1'b0, 3, 1, 0);

`ifdef ALIGN_CHECK_EN
        run_op("store be0", 1'b1, 10'h028, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0);
`else
        run_op("store be0", 1'b1, 10'h028, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 0, 0);
`endif

        preload(8'h09, 32'hA0B0C0D0);
`ifdef ALIGN_CHECK_EN
        run_op("store be0101", 1'b1, 10'h024, 4'b0101, 32'h11223344, 32'h0, 1'b1, 1, 0, 0);
        run_op("load 0x24", 1'b0, 10'h024, 4'b0000, 32'h0, 32'hA0B0C0D0, 1'b0, 3, 1, 0);
`else
        run_op("store be0101", 1'b1, 10'h024, 4'b0101, 32'h11223344, 32'h0, 1'b0, 4, 1, 1);
        run_op("load 0x24", 1'b0, 10'h024, 4'b0000, 32'h0, 32'hA022C044, 1'b0, 3, 1, 0);
`endif

        // Backpressure: response held while the consumer stalls.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 10'h014, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
        g = 0;
        while (!bus.rsp_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("bp rsp_valid rises", {31'd0, bus.rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
            check("bp req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp csb", {31'd0, sram_csb}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a read-modify-write; the aborted store is not scoreboarded.
        issue(1'b1, 10'h030, 4'b0001, 32'h000000FF, 32'h0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid-rst csb", {31'd0, sram_csb}, 32'd1);
        check("mid-rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid-rst addr", {24'd0, sram_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("post-rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        run_op("load after rst", 1'b0, 10'h014, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
